// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
// Defaults describe the standard 640x480@60 mode (25.175 MHz pixel clock).
package vga_pkg;

  // Horizontal timing, in pixels
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  // Vertical timing, in lines
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  // Counter width that holds 799 and 524
  localparam int DEF_CW     = 10;

  // Number of bits needed to hold the values 0 .. total-1 (never less than 1)
  function automatic int cnt_width(input int total);
    int w;
    w = 32'sd1;
    for (int i = 32'sd1; i < 32'sd31; i++) begin
      if (((total - 32'sd1) >>> i) > 32'sd0) begin
        w = i + 32'sd1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: a wrap counter over VIS+FP+SYNC+BP positions plus the
// sync-window and visible-region decode. Instantiated once for the
// horizontal axis (inc = pixel enable) and once for the vertical axis
// (inc = horizontal wrap), so both axes run on the single pixel clock.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int VIS  = DEF_H_VIS,
  parameter int FP   = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP,
  parameter bit POL  = 1'b0,
  parameter int CW   = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          vis_nxt,
  output logic          sync
);

  localparam int TOTAL = VIS + FP + SYNC + BP;
  // One extra bit on the window bounds so a window ending exactly at TOTAL
  // still compares correctly when TOTAL itself does not fit in CW bits.
  localparam int CWX   = CW + 1;

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 32'sd1);
  localparam logic [CW-1:0] ONE     = CW'(32'sd1);
  localparam logic [CW:0]   VIS_C   = CWX'(VIS);
  localparam logic [CW:0]   SYNC_LO = CWX'(VIS + FP);
  localparam logic [CW:0]   SYNC_HI = CWX'(VIS + FP + SYNC);

  logic [CW-1:0] count_r;
  logic          sync_r;
  logic [CW-1:0] count_nxt_s;
  logic [CW:0]   cnt_ext_s;
  logic          wrap_s;
  logic          sync_act_s;
  logic          vis_nxt_s;

  // Next count: hold when idle, wrap to zero after the last position
  always_comb begin
    wrap_s      = 1'b0;
    count_nxt_s = count_r;
    if (inc) begin
      if (count_r == LAST) begin
        wrap_s      = 1'b1;
        count_nxt_s = {CW{1'b0}};
      end else begin
        wrap_s      = 1'b0;
        count_nxt_s = count_r + ONE;
      end
    end else begin
      wrap_s      = 1'b0;
      count_nxt_s = count_r;
    end
  end

  // Decode the next count so the registered flags align with the registered count
  always_comb begin
    cnt_ext_s  = {1'b0, count_nxt_s};
    sync_act_s = (cnt_ext_s >= SYNC_LO) && (cnt_ext_s < SYNC_HI);
    vis_nxt_s  = (cnt_ext_s < VIS_C);
  end

  // Count and sync registers; reset parks the axis at position 0 with sync idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
      sync_r  <= ~POL;
    end else if (inc) begin
      count_r <= count_nxt_s;
      sync_r  <= sync_act_s ? POL : ~POL;
    end else begin
      count_r <= count_r;
      sync_r  <= sync_r;
    end
  end

  assign count   = count_r;
  assign sync    = sync_r;
  assign wrap    = wrap_s;
  assign vis_nxt = vis_nxt_s;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator feeding the gfx pixel pipeline.
// Produces h/v sync, display enable, pixel coordinates, line/frame strobes
// and a sticky vblank interrupt. Every output is a flop whose next value is
// decoded from the next counter values, so sync/enable never skew against
// the presented h_cnt/v_cnt. en acts as a clock enable; no clock is gated.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          irq_ack,
  output logic          h_sync,
  output logic          v_sync,
  output logic          d_out,
  output logic          d_out_b,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank,
  output logic          vbl_irq
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int CW_REQ  = (cnt_width(H_TOTAL) > cnt_width(V_TOTAL)) ?
                           cnt_width(H_TOTAL) : cnt_width(V_TOTAL);

  // Last visible line: leaving it on a line wrap means entering vblank
  localparam logic [CW-1:0] V_VIS_LAST = CW'(V_VIS - 32'sd1);

  // Refuse to build a generator whose counters cannot reach H_TOTAL-1 / V_TOTAL-1
  if (CW_REQ > CW) begin : g_cw_check
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] h_cnt_s;
  logic [CW-1:0] v_cnt_s;
  logic          h_wrap_s;
  logic          v_wrap_s;
  logic          h_vis_nxt_s;
  logic          v_vis_nxt_s;
  logic          h_sync_s;
  logic          v_sync_s;
  logic          irq_set_s;

  logic          d_out_r;
  logic          d_out_b_r;
  logic          vblank_r;
  logic          line_start_r;
  logic          frame_start_r;
  logic          vbl_irq_r;

  vga_axis_cnt #(
    .VIS  (H_VIS),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .BP   (H_BP),
    .POL  (H_POL),
    .CW   (CW)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (en),
    .count   (h_cnt_s),
    .wrap    (h_wrap_s),
    .vis_nxt (h_vis_nxt_s),
    .sync    (h_sync_s)
  );

  // Vertical axis steps only on a horizontal wrap, which already includes en
  vga_axis_cnt #(
    .VIS  (V_VIS),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .BP   (V_BP),
    .POL  (V_POL),
    .CW   (CW)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (h_wrap_s),
    .count   (v_cnt_s),
    .wrap    (v_wrap_s),
    .vis_nxt (v_vis_nxt_s),
    .sync    (v_sync_s)
  );

  // vblank entry: the line wrap that moves v_cnt from V_VIS-1 to V_VIS
  assign irq_set_s = h_wrap_s && (v_cnt_s == V_VIS_LAST);

  // Display enable and blanking from next counts; frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out_r   <= 1'b1;
      d_out_b_r <= 1'b0;
      vblank_r  <= 1'b0;
    end else if (en) begin
      d_out_r   <= h_vis_nxt_s & v_vis_nxt_s;
      d_out_b_r <= ~(h_vis_nxt_s & v_vis_nxt_s);
      vblank_r  <= ~v_vis_nxt_s;
    end else begin
      d_out_r   <= d_out_r;
      d_out_b_r <= d_out_b_r;
      vblank_r  <= vblank_r;
    end
  end

  // One-cycle strobes following an enabled wrap; wraps are already gated by en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      line_start_r  <= h_wrap_s;
      frame_start_r <= v_wrap_s;
    end
  end

  // Sticky vblank interrupt; a new entry beats a same-cycle acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vbl_irq_r <= 1'b0;
    end else if (irq_set_s) begin
      vbl_irq_r <= 1'b1;
    end else if (irq_ack) begin
      vbl_irq_r <= 1'b0;
    end else begin
      vbl_irq_r <= vbl_irq_r;
    end
  end

  assign h_cnt       = h_cnt_s;
  assign v_cnt       = v_cnt_s;
  assign h_sync      = h_sync_s;
  assign v_sync      = v_sync_s;
  assign d_out       = d_out_r;
  assign d_out_b     = d_out_b_r;
  assign vblank      = vblank_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign vbl_irq     = vbl_irq_r;

endmodule
